// File: rtl/sobel_window_pkg.sv
// sobel_window_pkg: pixel width, default image geometry shared with the sobel
// kernel, and a small address-width helper for the row memories.
package sobel_window_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_CNT_W = 10;

  typedef logic [PIX_W-1:0] pix_t;

  // Index width needed to address a memory of the given depth.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sobel_window_if.sv
// sobel_window_if: pixel stream in, 3x3 window out.
// With SOBEL_WIN_COORD_EN defined the interface also carries the window
// centre coordinates win_x / win_y (CNT_W bits each).
interface sobel_window_if
`ifdef SOBEL_WIN_COORD_EN
  #(parameter int CNT_W = sobel_window_pkg::DEF_CNT_W)
`endif
  ();
  import sobel_window_pkg::*;

  logic pix_valid;
  logic pix_sof;
  pix_t pix_in;
  pix_t z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic win_valid;
  logic frame_done;

`ifdef SOBEL_WIN_COORD_EN
  logic [CNT_W-1:0] win_x;
  logic [CNT_W-1:0] win_y;

  modport slave (
    input  pix_valid, pix_sof, pix_in,
    output z1, z2, z3, z4, z5, z6, z7, z8, z9, win_valid, frame_done, win_x, win_y
  );
  modport master (
    output pix_valid, pix_sof, pix_in,
    input  z1, z2, z3, z4, z5, z6, z7, z8, z9, win_valid, frame_done, win_x, win_y
  );
`else
  modport slave (
    input  pix_valid, pix_sof, pix_in,
    output z1, z2, z3, z4, z5, z6, z7, z8, z9, win_valid, frame_done
  );
  modport master (
    output pix_valid, pix_sof, pix_in,
    input  z1, z2, z3, z4, z5, z6, z7, z8, z9, win_valid, frame_done
  );
`endif

endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image row of pixels. The read port is combinational and
// returns the old contents in the same cycle a write to that address occurs.
// Contents are deliberately not reset.
module sobel_line_buf
  import sobel_window_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_W,
  parameter int ADDR_W = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pix_t              din,
  output pix_t              dout
);

  pix_t mem_q [DEPTH];

  // Store the incoming column value on every accepted pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/sobel_window.sv
// sobel_window: raster-order pixel stream to registered 3x3 neighbourhood.
// lb0 holds row r-1, lb1 holds row r-2; a window is flagged only once two full
// rows and two columns of the current row have been seen, which also hides
// stale line-buffer data after a frame restart or a row wrap.
// Optional: SOBEL_WIN_COORD_EN adds registered window centre win_x / win_y.
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst,
  sobel_window_if.slave bus
);

  localparam int              AW       = addr_bits(IMG_W);
  localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] r_cur_s, c_cur_s;
  pix_t [8:0]       z_q, z_d;        // index 0 = z1 ... index 8 = z9
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  pix_t             a0_s, a1_s;
`ifdef SOBEL_WIN_COORD_EN
  logic [CNT_W-1:0] win_x_q, win_x_d;
  logic [CNT_W-1:0] win_y_q, win_y_d;
`endif

  // Position of the current pixel: a start-of-frame pixel is always (0,0).
  always_comb begin
    if (bus.pix_sof) begin
      r_cur_s = ZERO;
      c_cur_s = ZERO;
    end else begin
      r_cur_s = row_q;
      c_cur_s = col_q;
    end
  end

  sobel_line_buf #(.DEPTH(IMG_W), .ADDR_W(AW)) u_lb0 (
    .clk  (clk),
    .we   (bus.pix_valid),
    .addr (c_cur_s[AW-1:0]),
    .din  (bus.pix_in),
    .dout (a0_s)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .ADDR_W(AW)) u_lb1 (
    .clk  (clk),
    .we   (bus.pix_valid),
    .addr (c_cur_s[AW-1:0]),
    .din  (a0_s),
    .dout (a1_s)
  );

  // Next-state: window shift, validity gate, counter advance and frame end.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    z_d          = z_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef SOBEL_WIN_COORD_EN
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
`endif
    if (bus.pix_valid) begin
      z_d[0] = z_q[1];
      z_d[1] = z_q[2];
      z_d[2] = a1_s;
      z_d[3] = z_q[4];
      z_d[4] = z_q[5];
      z_d[5] = a0_s;
      z_d[6] = z_q[7];
      z_d[7] = z_q[8];
      z_d[8] = bus.pix_in;
      win_valid_d = (r_cur_s >= TWO) && (c_cur_s >= TWO);
`ifdef SOBEL_WIN_COORD_EN
      if (win_valid_d) begin
        win_x_d = c_cur_s - ONE;
        win_y_d = r_cur_s - ONE;
      end else begin
        win_x_d = win_x_q;
        win_y_d = win_y_q;
      end
`endif
      if (c_cur_s == LAST_COL) begin
        col_d = ZERO;
        if (r_cur_s == LAST_ROW) begin
          row_d        = ZERO;
          frame_done_d = 1'b1;
        end else begin
          row_d = r_cur_s + ONE;
        end
      end else begin
        col_d = c_cur_s + ONE;
        row_d = r_cur_s;
      end
    end else begin
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= ZERO;
      col_q        <= ZERO;
      z_q          <= {(9 * PIX_W){1'b0}};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SOBEL_WIN_COORD_EN
      win_x_q      <= ZERO;
      win_y_q      <= ZERO;
`endif
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      z_q          <= z_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SOBEL_WIN_COORD_EN
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
`endif
    end
  end

  assign bus.z1         = z_q[0];
  assign bus.z2         = z_q[1];
  assign bus.z3         = z_q[2];
  assign bus.z4         = z_q[3];
  assign bus.z5         = z_q[4];
  assign bus.z6         = z_q[5];
  assign bus.z7         = z_q[6];
  assign bus.z8         = z_q[7];
  assign bus.z9         = z_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
`ifdef SOBEL_WIN_COORD_EN
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
`endif

endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: 4x4 image bench. A frame-image model records every accepted
// pixel at its frame position and predicts each window directly from the
// 3x3 neighbourhood of that image; frame end and window counts are predicted
// from the frame position alone.
module tb_sobel_window;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sobel_window_if
`ifdef SOBEL_WIN_COORD_EN
    #(.CNT_W(CW))
`endif
    u_if ();

  sobel_window #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int          n_cmp   = 0;
  int          n_bad   = 0;
  logic [7:0]  img [H][W];
  int          mr      = 0;
  int          mc      = 0;
  int          win_cnt = 0;
  int          exp_x   = 0;
  int          exp_y   = 0;
  logic [71:0] last_win  = 72'h0;
  logic [71:0] first_win = 72'h0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] obs_win();
    return {u_if.z1, u_if.z2, u_if.z3, u_if.z4, u_if.z5, u_if.z6, u_if.z7, u_if.z8, u_if.z9};
  endfunction

  // One clock: drive inputs, predict, clock, then compare.
  task automatic step(input logic v, input logic sof, input logic [7:0] p);
    logic        ev = 1'b0;
    logic        ed = 1'b0;
    logic [71:0] ew = 72'h0;
    int          r;
    int          c;
    u_if.pix_valid = v;
    u_if.pix_sof   = sof;
    u_if.pix_in    = p;
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
        win_cnt = 0;
      end
      r = mr;
      c = mc;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            ew = {ew[63:0], img[r-2+dr][c-2+dc]};
        exp_x = c - 1;
        exp_y = r - 1;
      end
      if (c == W - 1) begin
        mc = 0;
        if (r == H - 1) begin
          mr = 0;
          ed = 1'b1;
        end else begin
          mr = r + 1;
        end
      end else begin
        mc = c + 1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("win_valid", 72'(u_if.win_valid), 72'(ev));
    check_eq("frame_done", 72'(u_if.frame_done), 72'(ed));
    if (ev) begin
      check_eq("window", obs_win(), ew);
    end
`ifdef SOBEL_WIN_COORD_EN
    check_eq("win_x", 72'(u_if.win_x), 72'(exp_x));
    check_eq("win_y", 72'(u_if.win_y), 72'(exp_y));
`endif
    if (u_if.win_valid) begin
      if (win_cnt == 0) first_win = obs_win();
      last_win = obs_win();
      win_cnt++;
    end
    if (u_if.frame_done) begin
      check_eq("win_count", 72'(win_cnt), 72'((W - 2) * (H - 2)));
      win_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    u_if.pix_valid = 1'b0;
    u_if.pix_sof   = 1'b0;
    u_if.pix_in    = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mr = 0;
    mc = 0;
    win_cnt = 0;
    exp_x = 0;
    exp_y = 0;
    check_eq("rst_win_valid", 72'(u_if.win_valid), 72'h0);
    check_eq("rst_frame_done", 72'(u_if.frame_done), 72'h0);
    check_eq("rst_window", obs_win(), 72'h0);
`ifdef SOBEL_WIN_COORD_EN
    check_eq("rst_win_x", 72'(u_if.win_x), 72'h0);
    check_eq("rst_win_y", 72'(u_if.win_y), 72'h0);
`endif
  endtask

  // Pixels from linear index lo to hi-1. mode: 0 no gaps, 1 two idles after
  // each pixel, 2 random 0..2 idles. rnd selects random pixel values.
  task automatic send_px(input int lo, input int hi, input int base, input int mode,
                         input bit rnd, input bit sof_first);
    logic [7:0] p;
    int         gaps;
    for (int i = lo; i < hi; i++) begin
      p = rnd ? 8'($urandom) : 8'(base + 16 * (i / W) + (i % W));
      step(1'b1, sof_first && (i == lo), p);
      gaps = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    u_if.pix_valid = 1'b0;
    u_if.pix_sof   = 1'b0;
    u_if.pix_in    = 8'h00;
    do_reset();

    // Full frame, continuous valid.
    send_px(0, 16, 0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check_eq("f1_first_window", first_win, 72'h000102101112202122);
    check_eq("f1_last_window", last_win, 72'h111213212223313233);

    // Same frame with 1,0,0 valid pattern.
    send_px(0, 16, 0, 1, 1'b0, 1'b1);
    check_eq("gap_last_window", last_win, 72'h111213212223313233);

    // Back-to-back frames, second offset by 0x80.
    send_px(0, 16, 0, 0, 1'b0, 1'b1);
    send_px(0, 16, 8'h80, 0, 1'b0, 1'b1);
    check_eq("f2_first_window", first_win, 72'h808182909192a0a1a2);

    // Restart mid-frame at position (2,1).
    send_px(0, 9, 0, 0, 1'b0, 1'b1);
    send_px(0, 16, 0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);

    // Reset after pixel (3,0), then a full frame without pix_sof.
    send_px(0, 13, 0, 0, 1'b0, 1'b1);
    do_reset();
    send_px(0, 16, 8'h40, 0, 1'b0, 1'b0);
    check_eq("post_rst_last_window", last_win, 72'h515253616263717273);

    // Random pixels, random gaps, occasional abandoned frames.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) send_px(0, int'($urandom_range(1, 15)), 0, 2, 1'b1, 1'b1);
      send_px(0, 16, 0, 2, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
